fir_tap_sequencer: RTL and testbench

- Upstream control and datapath stage for the MAC ALU in the FIR filter.
- Accepts input samples over a valid/ready handshake and stores them in a circular delay line.
- For each accepted sample, streams TAPS sample/coefficient operand pairs into the MAC, clearing the MAC first.
- Captures the finished accumulation and presents it downstream over a valid/ready handshake.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/fir_tap_sequencer_if.sv | 32 +++
 rtl/fir_delay_line.sv | 40 ++++
 rtl/fir_tap_sequencer.sv | 128 ++++++++++++
 tb/tb_fir_tap_sequencer.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap sequencer and its delay line.
// Holds operand/accumulator widths, the sequencer state encoding and the 32-bit clamp helper.
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 39;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        CAPT = 2'd2,
        OUT  = 2'd3
    } state_t;

    // 2^31-1 and -2^31, sign-extended to the accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = 39'sh00_7FFF_FFFF;
    localparam logic signed [ACC_W-1:0] SAT_MIN = 39'sh7F_8000_0000;

    function automatic logic signed [ACC_W-1:0] sat32(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W-1:0] r;
        r = v;
        if (v > SAT_MAX) begin
            r = SAT_MAX;
        end else if (v < SAT_MIN) begin
            r = SAT_MIN;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
// Bundle of sample-in, coefficient-write, MAC operand and result-out signals of the sequencer.
// slave is the sequencer side; master is the surrounding logic (source, MAC, sink).
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 4
);
    import fir_pkg::*;

    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_sample;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [DATA_W-1:0] coef_wdata;
    logic signed [DATA_W-1:0] alu_x;
    logic signed [DATA_W-1:0] alu_b;
    logic                     alu_clr;
    logic signed [ACC_W-1:0]  acc_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;

    modport slave (
        input  in_valid, in_sample, coef_we, coef_addr, coef_wdata, acc_in, out_ready,
        output in_ready, alu_x, alu_b, alu_clr, out_valid, out_data
    );

    modport master (
        output in_valid, in_sample, coef_we, coef_addr, coef_wdata, acc_in, out_ready,
        input  in_ready, alu_x, alu_b, alu_clr, out_valid, out_data
    );

endinterface

// File: rtl/fir_delay_line.sv
// Circular sample buffer: one write per accepted sample, combinational read of line[newest-k].
// Synchronous reset clears every entry and both pointers; no flow control of its own.
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int TAPS   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     R,
    input  logic                     i_wr_en,
    input  logic signed [DATA_W-1:0] i_wr_dat,
    input  logic [ADDR_W-1:0]        i_k,
    output logic signed [DATA_W-1:0] o_rd_dat
);

    logic signed [DATA_W-1:0] r_line [TAPS];
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [ADDR_W-1:0]        r_newest;
    logic [ADDR_W-1:0]        w_rd_addr;

    always_ff @(posedge clk) begin
        if (R) begin
            for (int i = 0; i < TAPS; i++) begin
                r_line[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_newest <= '0;
        end else if (i_wr_en) begin
            r_line[r_wr_ptr] <= i_wr_dat;
            r_newest         <= r_wr_ptr;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
        end
    end

    // ADDR_W-bit subtraction gives the modulo-TAPS wrap for free.
    assign w_rd_addr = r_newest - i_k;
    assign o_rd_dat  = r_line[w_rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Feeds TAPS sample/coef pairs to the MAC per accepted sample; result valid TAPS+2 cycles after accept.
// Holds in OUT (in_ready low) until out_ready; define FIR_SAT32_EN to clamp the result to 32 bits.
module fir_tap_sequencer
    import fir_pkg::*;
#(
    parameter int TAPS   = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                R,
    fir_tap_sequencer_if.slave  bus
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [ADDR_W-1:0]        r_k;
    logic [ADDR_W-1:0]        w_k_nxt;
    logic signed [DATA_W-1:0] r_coef [TAPS];
    logic signed [ACC_W-1:0]  r_out_data;
    logic signed [ACC_W-1:0]  w_capt;
    logic signed [DATA_W-1:0] w_line_rd;
    logic                     w_accept;
    logic                     w_coef_wr;
    logic                     w_in_ready;
    logic                     w_out_valid;
    logic                     w_alu_clr;
    logic signed [DATA_W-1:0] w_alu_x;
    logic signed [DATA_W-1:0] w_alu_b;

    assign w_accept  = (r_state == IDLE) && bus.in_valid;
    // Writes only land between filter outputs so one result never mixes coefficient sets.
    assign w_coef_wr = bus.coef_we && ((r_state == IDLE) || (r_state == OUT));

    fir_delay_line #(
        .TAPS   (TAPS),
        .ADDR_W (ADDR_W)
    ) u_delay_line (
        .clk      (clk),
        .R        (R),
        .i_wr_en  (w_accept),
        .i_wr_dat (bus.in_sample),
        .i_k      (r_k),
        .o_rd_dat (w_line_rd)
    );

    always_ff @(posedge clk) begin
        if (R) begin
            r_state <= IDLE;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (R) begin
            for (int i = 0; i < TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (w_coef_wr) begin
            r_coef[bus.coef_addr] <= bus.coef_wdata;
        end
    end

`ifdef FIR_SAT32_EN
    assign w_capt = sat32(bus.acc_in);
`else
    assign w_capt = bus.acc_in;
`endif

    always_ff @(posedge clk) begin
        if (R) begin
            r_out_data <= '0;
        end else if (r_state == CAPT) begin
            r_out_data <= w_capt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_alu_clr   = 1'b0;
        w_alu_x     = '0;
        w_alu_b     = '0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                w_alu_clr  = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = MAC;
                    w_k_nxt     = '0;
                end
            end
            MAC: begin
                w_alu_x = w_line_rd;
                w_alu_b = r_coef[r_k];
                w_k_nxt = r_k + 1'b1;
                if (r_k == ADDR_W'(TAPS - 1)) begin
                    w_state_nxt = CAPT;
                end
            end
            CAPT: begin
                w_state_nxt = OUT;
            end
            OUT: begin
                w_out_valid = 1'b1;
                w_alu_clr   = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.alu_clr   = w_alu_clr;
    assign bus.alu_x     = w_alu_x;
    assign bus.alu_b     = w_alu_b;
    assign bus.out_data  = r_out_data;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: behavioural MAC, convolution reference model and output scoreboard.
// Directed steps: reset, impulse, step, coef write in MAC, extremes, backpressure, reset mid-MAC.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    localparam int TAPS = 16;

    logic clk = 1'b0;
    logic R;
    int   checks = 0;
    int   errors = 0;

    fir_tap_sequencer_if #(.ADDR_W(4)) bus ();

    fir_tap_sequencer #(
        .TAPS   (TAPS),
        .ADDR_W (4)
    ) dut (
        .clk (clk),
        .R   (R),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // MAC behaviour: y <= y + sext(x*b), cleared on edges where alu_clr is high.
    logic signed [38:0] acc = '0;
    logic signed [31:0] prod;
    assign prod       = bus.alu_x * bus.alu_b;
    assign bus.acc_in = acc;
    always @(posedge clk) begin
        if (bus.alu_clr) acc <= '0;
        else             acc <= acc + {{7{prod[31]}}, prod};
    end

    logic signed [15:0] m_coef [TAPS];
    logic signed [15:0] m_hist [TAPS];
    logic signed [38:0] sb [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) begin
            m_coef[i] = '0;
            m_hist[i] = '0;
        end
        sb.delete();
    endtask

    task automatic model_accept(input logic signed [15:0] x);
        logic signed [38:0] s;
        logic signed [31:0] p;
        s = '0;
        for (int i = TAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = x;
        for (int i = 0; i < TAPS; i++) begin
            p = m_hist[i] * m_coef[i];
            s = s + {{7{p[31]}}, p};
        end
`ifdef FIR_SAT32_EN
        if (s > 39'sh00_7FFF_FFFF) s = 39'sh00_7FFF_FFFF;
        if (s < 39'sh7F_8000_0000) s = 39'sh7F_8000_0000;
`endif
        sb.push_back(s);
    endtask

    task automatic write_coef(input int a, input logic signed [15:0] v);
        bus.coef_addr  = 4'(a);
        bus.coef_wdata = v;
        bus.coef_we    = 1'b1;
        @(negedge clk);
        bus.coef_we    = 1'b0;
        m_coef[a]      = v;
    endtask

    // Called at a negedge; returns at the negedge one cycle after the accepting edge.
    task automatic send(input logic signed [15:0] x);
        int n;
        bus.in_sample = x;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 64'(n >= 100), 64'd0);
        model_accept(x);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic collect(output logic signed [38:0] got, output int lat);
        logic signed [38:0] exp;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("output_timeout", 64'(lat >= 100), 64'd0);
        got = bus.out_data;
        check("scoreboard_nonempty", 64'(sb.size() == 0), 64'd0);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        check("out_data_vs_model", 64'(got), 64'(exp));
    endtask

    initial begin
        logic signed [38:0] got;
        logic signed [38:0] held;
        int lat;
        int lim;

        R              = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sample  = '0;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = '0;
        bus.coef_wdata = '0;
        bus.out_ready  = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        R = 1'b0;

        check("reset_in_ready",  64'(bus.in_ready),  64'd1);
        check("reset_out_valid", 64'(bus.out_valid), 64'd0);
        check("reset_alu_clr",   64'(bus.alu_clr),   64'd1);
        check("reset_alu_x",     64'(bus.alu_x),     64'd0);
        check("reset_out_data",  64'(bus.out_data),  64'd0);

        // Impulse: coef[k]=k+1, feed 1 then 16 zeros.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
        for (int i = 0; i <= TAPS; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0);
            collect(got, lat);
            if (i == 0) check("impulse_latency", 64'(lat), 64'd18);
            check("impulse_value", 64'(got), 64'((i < TAPS) ? i + 1 : 0));
        end

        // Step: all coef=1, feed 100 twenty times.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd1);
        for (int i = 0; i < 20; i++) begin
            send(16'sd100);
            collect(got, lat);
            lim = (i + 1 < TAPS) ? i + 1 : TAPS;
            check("step_value", 64'(got), 64'(100 * lim));
        end

        // Coefficient write during MAC is dropped.
        send(16'sd100);
        repeat (2) @(negedge clk);
        bus.coef_addr  = 4'd0;
        bus.coef_wdata = 16'sd7;
        bus.coef_we    = 1'b1;
        @(negedge clk);
        bus.coef_we    = 1'b0;
        collect(got, lat);
        check("mac_write_current", 64'(got), 64'd1600);
        send(16'sd1);
        collect(got, lat);
        check("mac_write_dropped", 64'(got), 64'd1501);

        // Extremes: most negative coefficient and sample everywhere.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sh8000);
        for (int i = 0; i < TAPS; i++) begin
            send(16'sh8000);
            collect(got, lat);
        end
`ifdef FIR_SAT32_EN
        check("extreme_value", 64'(got), 64'(39'sh00_7FFF_FFFF));
`else
        check("extreme_value", 64'(got), 64'(39'sh04_0000_0000));
`endif

        // Backpressure: hold OUT for 10 cycles with the next sample pending.
        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(k + 1));
        bus.out_ready = 1'b0;
        send(16'sd3);
        collect(got, lat);
        held          = got;
        bus.in_sample = 16'sd5;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 64'(bus.out_valid), 64'd1);
            check("bp_out_data",  64'(bus.out_data),  64'(held));
            check("bp_in_ready",  64'(bus.in_ready),  64'd0);
        end
        bus.out_ready = 1'b1;
        send(16'sd5);
        collect(got, lat);

        // Reset at MAC cycle 5 clears state and coefficients.
        send(16'sd9);
        repeat (4) @(negedge clk);
        R = 1'b1;
        @(negedge clk);
        R = 1'b0;
        model_clear();
        check("rst_mid_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_mid_alu_clr",   64'(bus.alu_clr),   64'd1);
        check("rst_mid_alu_b",     64'(bus.alu_b),     64'd0);
        check("rst_mid_out_data",  64'(bus.out_data),  64'd0);
        for (int i = 0; i < 3; i++) begin
            send((i == 0) ? 16'sd1 : 16'sd0);
            collect(got, lat);
            check("rst_impulse_zero", 64'(got), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
